// File: rtl/adder_eval_pkg.sv
// Shared types and helpers for the adder hardware-evaluation wrappers:
// MISR state encoding, the default CRC-32 taps and a generic XOR fold.
package adder_eval_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } misr_state_t;

    localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;

    // Upper bounds for the generic fold helper below.
    localparam int MAX_IN_W  = 1024;
    localparam int MAX_SIG_W = 64;

    // XOR-fold the low in_w bits of data into sig_w-bit slices (slice 0 = LSBs,
    // top slice implicitly zero-extended). Bits above sig_w in the result are 0.
    function automatic logic [MAX_SIG_W-1:0] xor_fold(input logic [MAX_IN_W-1:0] data,
                                                      input int in_w,
                                                      input int sig_w);
        logic [MAX_SIG_W-1:0] res;
        res = {MAX_SIG_W{1'b0}};
        for (int i = 0; i < MAX_IN_W; i++) begin
            if (i < in_w) begin
                res[i % sig_w] = res[i % sig_w] ^ data[i];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wide_xor_fold.sv
// Purely combinational fold of a wide word into SIG_WIDTH bits by XOR of all
// SIG_WIDTH-bit slices; the partial top slice is zero-extended.
module wide_xor_fold
    import adder_eval_pkg::*;
#(
    parameter int IN_WIDTH  = 500,
    parameter int SIG_WIDTH = 32
) (
    input  logic [IN_WIDTH-1:0]  i_data,
    output logic [SIG_WIDTH-1:0] o_fold
);
    localparam int NSLICE = (IN_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
    localparam int PAD_W  = NSLICE * SIG_WIDTH;

    logic [PAD_W-1:0] w_pad;

    // Zero-extend the input to a whole number of slices.
    always_comb begin
        w_pad                 = {PAD_W{1'b0}};
        w_pad[IN_WIDTH-1:0]   = i_data;
    end

    // XOR all slices together.
    always_comb begin
        o_fold = {SIG_WIDTH{1'b0}};
        for (int s = 0; s < NSLICE; s++) begin
            o_fold = o_fold ^ w_pad[s*SIG_WIDTH +: SIG_WIDTH];
        end
    end

endmodule

// File: rtl/adder_result_misr.sv
// Response compactor: folds each accepted result word to SIG_WIDTH bits and
// compacts SAMPLE_COUNT words into a Galois MISR signature.
module adder_result_misr
    import adder_eval_pkg::*;
#(
    parameter int                   IN_WIDTH     = 500,
    parameter int                   SIG_WIDTH    = 32,
    parameter logic [SIG_WIDTH-1:0] POLY         = SIG_WIDTH'(CRC32_POLY),
    parameter logic [SIG_WIDTH-1:0] SEED         = {SIG_WIDTH{1'b1}},
    parameter int                   SAMPLE_COUNT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic [SIG_WIDTH-1:0] sig,
    output logic                 sig_valid,
    output logic                 busy
);
    localparam int               CNT_W    = $clog2(SAMPLE_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_COUNT);

    misr_state_t          r_state;
    misr_state_t          w_state_nxt;
    logic [CNT_W-1:0]     r_cnt;
    logic [SIG_WIDTH-1:0] r_sig;
    logic [SIG_WIDTH-1:0] r_fold_q;
    logic [SIG_WIDTH-1:0] w_fold;
    logic [SIG_WIDTH-1:0] w_sig_step;
    logic                 r_fold_v;
    logic                 r_sig_valid;
    logic                 r_busy;
    logic                 w_accept;
    logic                 w_load;
    logic                 w_last;
    logic                 w_busy_nxt;
    logic                 w_sig_valid_nxt;

    wide_xor_fold #(
        .IN_WIDTH  (IN_WIDTH),
        .SIG_WIDTH (SIG_WIDTH)
    ) u_fold (
        .i_data (in_data),
        .o_fold (w_fold)
    );

    // A word counts only while running; start is honoured only between runs,
    // so a start cycle never accepts a word and a run cannot be restarted.
    assign w_accept = (r_state == RUN) && in_valid;
    assign w_load   = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = w_accept && (r_cnt == (CNT_LAST - CNT_W'(1)));

    // One Galois shift with the registered fold injected.
    assign w_sig_step = {r_sig[SIG_WIDTH-2:0], 1'b0}
                      ^ (r_sig[SIG_WIDTH-1] ? POLY : {SIG_WIDTH{1'b0}})
                      ^ r_fold_q;

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic; DRAIN gives the last fold one cycle to land.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start  ? RUN  : IDLE;
            RUN:     w_state_nxt = w_last ? DRAIN : RUN;
            DRAIN:   w_state_nxt = DONE;
            DONE:    w_state_nxt = start  ? RUN  : DONE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode from the next state so the registered flags align with the state.
    always_comb begin
        w_busy_nxt      = 1'b0;
        w_sig_valid_nxt = 1'b0;
        case (w_state_nxt)
            RUN, DRAIN: w_busy_nxt      = 1'b1;
            DONE:       w_sig_valid_nxt = 1'b1;
            default: begin
                w_busy_nxt      = 1'b0;
                w_sig_valid_nxt = 1'b0;
            end
        endcase
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_busy      <= 1'b0;
            r_sig_valid <= 1'b0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_sig_valid <= w_sig_valid_nxt;
        end
    end

    // Fold pipeline stage: breaks the wide XOR tree away from the MISR feedback.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fold_q <= {SIG_WIDTH{1'b0}};
            r_fold_v <= 1'b0;
        end else begin
            r_fold_q <= w_fold;
            r_fold_v <= w_accept;
        end
    end

    // Accepted-word counter for the current run.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_load) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Signature register: reseeded on start, advanced only by a valid fold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sig <= SEED;
        end else if (w_load) begin
            r_sig <= SEED;
        end else if (r_fold_v) begin
            r_sig <= w_sig_step;
        end else begin
            r_sig <= r_sig;
        end
    end

    assign sig       = r_sig;
    assign sig_valid = r_sig_valid;
    assign busy      = r_busy;

endmodule

// File: tb/tb_adder_result_misr.sv
// Scoreboard bench for adder_result_misr: two small 16->8 configurations and
// the default 500->32 configuration against a software fold + MISR model.
module tb_adder_result_misr;
    import adder_eval_pkg::*;

    logic        clk;
    logic        resetn;

    logic        a_start, a_valid, a_sig_valid, a_busy;
    logic [15:0] a_data;
    logic [7:0]  a_sig;

    logic        b_start, b_valid, b_sig_valid, b_busy;
    logic [15:0] b_data;
    logic [7:0]  b_sig;

    logic         c_start, c_valid, c_sig_valid, c_busy;
    logic [499:0] c_data;
    logic [31:0]  c_sig;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  exp_a[$];
    logic [7:0]  exp_b[$];
    logic [31:0] exp_c[$];
    logic [7:0]  b_walk[$];

    logic        a_prev_v = 1'b0;
    logic        b_prev_v = 1'b0;
    logic        c_prev_v = 1'b0;
    logic [7:0]  b_prev_sig = 8'h01;

    adder_result_misr #(.IN_WIDTH(16), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h00), .SAMPLE_COUNT(2)) dut_a (
        .clk(clk), .resetn(resetn), .start(a_start), .in_valid(a_valid), .in_data(a_data),
        .sig(a_sig), .sig_valid(a_sig_valid), .busy(a_busy));

    adder_result_misr #(.IN_WIDTH(16), .SIG_WIDTH(8), .POLY(8'h1D), .SEED(8'h01), .SAMPLE_COUNT(8)) dut_b (
        .clk(clk), .resetn(resetn), .start(b_start), .in_valid(b_valid), .in_data(b_data),
        .sig(b_sig), .sig_valid(b_sig_valid), .busy(b_busy));

    adder_result_misr dut_c (
        .clk(clk), .resetn(resetn), .start(c_start), .in_valid(c_valid), .in_data(c_data),
        .sig(c_sig), .sig_valid(c_sig_valid), .busy(c_busy));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [63:0] misr_step(input logic [63:0] s, input logic [63:0] f,
                                              input logic [63:0] poly, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return (((s << 1) & mask) ^ (s[w-1] ? poly : 64'd0) ^ f) & mask;
    endfunction

    function automatic logic [7:0] fold8(input logic [15:0] d);
        logic [MAX_SIG_W-1:0] f;
        f = xor_fold(MAX_IN_W'(d), 16, 8);
        return f[7:0];
    endfunction

    function automatic logic [31:0] fold32(input logic [499:0] d);
        logic [MAX_SIG_W-1:0] f;
        f = xor_fold(MAX_IN_W'(d), 500, 32);
        return f[31:0];
    endfunction

    function automatic logic [499:0] rand500();
        logic [511:0] t;
        for (int k = 0; k < 16; k++) t[k*32 +: 32] = $urandom;
        return t[499:0];
    endfunction

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int which);
        logic v;
        for (int k = 0; k < 40; k++) begin
            v = (which == 0) ? a_sig_valid : (which == 1) ? b_sig_valid : c_sig_valid;
            if (v) break;
            tick();
        end
        v = (which == 0) ? a_sig_valid : (which == 1) ? b_sig_valid : c_sig_valid;
        check("done_within_budget", 64'(v), 64'd1);
    endtask

    // Monitor: pop one expected signature on each rising sig_valid.
    always @(negedge clk) begin
        if (a_sig_valid && !a_prev_v) begin
            if (exp_a.size() == 0) check("a_unexpected_done", 64'd1, 64'd0);
            else check("a_signature", 64'(a_sig), 64'(exp_a.pop_front()));
        end
        if (b_sig_valid && !b_prev_v) begin
            if (exp_b.size() == 0) check("b_unexpected_done", 64'd1, 64'd0);
            else check("b_signature", 64'(b_sig), 64'(exp_b.pop_front()));
        end
        if (c_sig_valid && !c_prev_v) begin
            if (exp_c.size() == 0) check("c_unexpected_done", 64'd1, 64'd0);
            else check("c_signature", 64'(c_sig), 64'(exp_c.pop_front()));
        end
        if (b_sig !== b_prev_sig) b_walk.push_back(b_sig);
        a_prev_v   <= a_sig_valid;
        b_prev_v   <= b_sig_valid;
        c_prev_v   <= c_sig_valid;
        b_prev_sig <= b_sig;
    end

    // ---------------- stimulus helpers ----------------
    task automatic a_send(input logic [15:0] d);
        a_valid = 1'b1;
        a_data  = d;
        tick();
        a_valid = 1'b0;
    endtask

    task automatic a_pulse_start();
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_random_run();
        logic [63:0] acc;
        logic [15:0] w;
        acc = 64'h00;
        a_pulse_start();
        for (int n = 0; n < 2; n++) begin
            repeat ($urandom_range(0, 2)) tick();
            w   = 16'($urandom);
            acc = misr_step(acc, 64'(fold8(w)), 64'h1D, 8);
            if (n == 1) exp_a.push_back(acc[7:0]);
            a_send(w);
        end
        wait_done(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0]  acc;
        logic [499:0] w;
        logic [7:0]   e8;

        resetn = 1'b0;
        a_start = 1'b0; a_valid = 1'b0; a_data = 16'h0;
        b_start = 1'b0; b_valid = 1'b0; b_data = 16'h0;
        c_start = 1'b0; c_valid = 1'b0; c_data = '0;
        #12;
        check("reset_a_sig", 64'(a_sig), 64'h00);
        check("reset_a_sig_valid", 64'(a_sig_valid), 64'd0);
        check("reset_a_busy", 64'(a_busy), 64'd0);
        check("reset_b_sig", 64'(b_sig), 64'h01);
        check("reset_c_sig", 64'(c_sig), 64'hFFFF_FFFF);
        check("reset_c_busy", 64'(c_busy), 64'd0);
        resetn = 1'b1;
        tick();

        // in_valid while IDLE is ignored
        a_send(16'hBEEF);
        check("a_idle_busy", 64'(a_busy), 64'd0);
        check("a_idle_fold_v", 64'(dut_a.r_fold_v), 64'd0);

        // Basic compaction with exact latency
        a_pulse_start();
        check("a_busy_run", 64'(a_busy), 64'd1);
        a_valid = 1'b1; a_data = 16'h1234;
        tick();
        check("a_fold_word0", 64'(dut_a.r_fold_q), 64'h26);
        a_data = 16'h00FF;
        tick();
        a_valid = 1'b0;
        check("a_fold_word1", 64'(dut_a.r_fold_q), 64'hFF);
        exp_a.push_back(8'hB3);
        check("a_valid_at_c1", 64'(a_sig_valid), 64'd0);
        check("a_busy_drain", 64'(a_busy), 64'd1);
        tick();
        check("a_valid_at_c2", 64'(a_sig_valid), 64'd1);
        check("a_sig_at_c2", 64'(a_sig), 64'hB3);
        check("a_busy_done", 64'(a_busy), 64'd0);

        // in_valid while DONE is ignored
        a_send(16'hAAAA);
        tick();
        check("a_done_frozen", 64'(a_sig), 64'hB3);
        check("a_done_valid_held", 64'(a_sig_valid), 64'd1);

        // Gapped valid plus a word beyond the count
        a_pulse_start();
        a_send(16'h1234);
        repeat (3) tick();
        a_send(16'h00FF);
        exp_a.push_back(8'hB3);
        a_send(16'h5555);
        wait_done(0);
        check("a_busy_done_gapped", 64'(a_busy), 64'd0);
        tick();
        check("a_sig_after_extra_word", 64'(a_sig), 64'hB3);

        // start in DONE together with in_valid: reseed, word dropped
        a_start = 1'b1; a_valid = 1'b1; a_data = 16'h7777;
        tick();
        a_start = 1'b0; a_valid = 1'b0;
        check("a_restart_valid_drop", 64'(a_sig_valid), 64'd0);
        check("a_restart_seed", 64'(a_sig), 64'h00);
        a_send(16'h1234);
        a_pulse_start();  // mid-RUN, ignored
        a_send(16'h00FF);
        exp_a.push_back(8'hB3);
        wait_done(0);

        repeat (4) a_random_run();

        // Feedback path: seed 01, eight zero words
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        b_valid = 1'b1; b_data = 16'h0000;
        repeat (8) tick();
        b_valid = 1'b0;
        exp_b.push_back(8'h1D);
        wait_done(1);
        tick();
        check("b_walk_length", 64'(b_walk.size() >= 8), 64'd1);
        for (int k = 0; k < 8 && k < b_walk.size(); k++) begin
            e8 = (k < 7) ? (8'h01 << (k + 1)) : 8'h1D;
            check("b_walk_step", 64'(b_walk[k]), 64'(e8));
        end

        // Asynchronous reset mid-run on A and C
        a_start = 1'b1; c_start = 1'b1;
        tick();
        a_start = 1'b0; c_start = 1'b0;
        a_valid = 1'b1; a_data = 16'h1234; c_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            c_data = rand500();
            tick();
            a_valid = 1'b0;
        end
        c_valid = 1'b0;
        check("a_partial_sig", 64'(a_sig), 64'h26);
        check("c_busy_run", 64'(c_busy), 64'd1);
        #3;
        resetn = 1'b0;
        #1;
        check("async_a_sig", 64'(a_sig), 64'h00);
        check("async_a_busy", 64'(a_busy), 64'd0);
        check("async_a_sig_valid", 64'(a_sig_valid), 64'd0);
        check("async_c_sig", 64'(c_sig), 64'hFFFF_FFFF);
        check("async_c_busy", 64'(c_busy), 64'd0);
        check("async_c_sig_valid", 64'(c_sig_valid), 64'd0);
        #2;
        resetn = 1'b1;
        tick();

        a_random_run();

        // Default configuration: 1024 random 500-bit words with random gaps
        c_start = 1'b1;
        tick();
        c_start = 1'b0;
        acc = 64'hFFFF_FFFF;
        for (int n = 0; n < 1024; n++) begin
            if ($urandom_range(0, 7) == 0) tick();
            w   = rand500();
            acc = misr_step(acc, 64'(fold32(w)), 64'(CRC32_POLY), 32);
            if (n == 1023) exp_c.push_back(acc[31:0]);
            c_valid = 1'b1;
            c_data  = w;
            tick();
            c_valid = 1'b0;
        end
        c_valid = 1'b1;
        c_data  = rand500();
        tick();
        c_valid = 1'b0;
        wait_done(2);
        check("c_busy_done", 64'(c_busy), 64'd0);
        tick();

        check("a_queue_drained", 64'(exp_a.size()), 64'd0);
        check("b_queue_drained", 64'(exp_b.size()), 64'd0);
        check("c_queue_drained", 64'(exp_c.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/adder_result_misr.md
Name: adder_result_misr

Overview:
- Response-side companion to the LFSR stimulus generators used in adder hardware-evaluation wrappers.
- Consumes a wide, valid-qualified result bus, for example the 500-bit S of a pipelined 4:2:1 adder.
- XOR-folds each accepted word to SIG_WIDTH bits and compacts a programmed number of words into a Galois MISR signature.
- Purpose: hardware runs expose only a few output pins, and one signature compare replaces a full-width result dump.

Parameters:
- IN_WIDTH, 500: width of the result bus.
- SIG_WIDTH, 32: signature width. Must be ≥ 2 and ≤ IN_WIDTH.
- POLY, 32'h04C11DB7: Galois feedback taps, SIG_WIDTH bits.
- SEED, all ones: signature value loaded on reset and on start, SIG_WIDTH bits.
- SAMPLE_COUNT, 1024: number of valid words compacted per run. Must be ≥ 1.

Ports:
- clk  input  1  clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse that arms a new run.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  IN_WIDTH  result word.
- sig  output  SIG_WIDTH  current MISR register. Final only while sig_valid=1.
- sig_valid  output  1  signature complete; held until the next accepted start.
- busy  output  1  high in RUN and DRAIN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, sig=SEED, sig_valid=0, busy=0, sample counter=0, fold_q=0, fold_v=0.
- Fold: fold = XOR of all SIG_WIDTH-bit slices of in_data. Slice 0 is the LSBs. The top slice is zero-extended when IN_WIDTH is not a multiple of SIG_WIDTH.
- Fold pipeline register: fold_q <= fold and fold_v <= accept, where accept = (state==RUN) && in_valid.
- MISR update, only when fold_v=1: sig <= {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold_q.
- Counter: width $clog2(SAMPLE_COUNT+1). Increments on each accept.
- IDLE:
  - busy=0, sig_valid=0.
  - start: sig<=SEED, counter<=0, go to RUN.
- RUN:
  - Accepts words.
  - When the accept that makes counter==SAMPLE_COUNT occurs, go to DRAIN.
- DRAIN:
  - Lasts exactly one cycle; the last fold_q updates the MISR.
  - Then go to DONE.
- DONE:
  - sig_valid=1, busy=0, sig frozen.
  - start: sig<=SEED, counter<=0, sig_valid<=0, go to RUN.
- Latency: last word presented at cycle c. fold_q is valid at c+1. sig is final and sig_valid=1 at c+2.
- start during RUN or DRAIN is ignored. A run is never restarted mid-flight.
- in_valid in IDLE, DONE, DRAIN, or the start cycle is ignored. Words beyond SAMPLE_COUNT are ignored.
- Gaps in in_valid only stall counting. sig changes only on fold_v.
- start and in_valid in the same cycle: start is taken and the word is dropped. The first accepted word is in the following cycle.
- Reset asserted mid-run: immediate return to reset values. No partial signature is exposed.

Decomposition:
- Shared package adder_eval_pkg holds:
  - state enum misr_state_t {IDLE, RUN, DRAIN, DONE};
  - the default CRC-32 polynomial constant;
  - a function xor_fold(IN_WIDTH, SIG_WIDTH), reused by the bench's reference model.
- One sub-module is natural: wide_xor_fold, purely combinational and parameterised by IN_WIDTH and SIG_WIDTH.
- The MISR, counter and FSM stay in the top module.

Test Plan:
- Basic compaction. Setup: IN_WIDTH=16, SIG_WIDTH=8, POLY=8'h1D, SEED=8'h00, SAMPLE_COUNT=2. Stimulus: start, then 16'h1234 and 16'h00FF on consecutive cycles. Required: fold values 8'h26 and 8'hFF; sig=8'hB3 with sig_valid=1 two cycles after the last word.
- Feedback path. Same configuration with SEED=8'h01, SAMPLE_COUNT=8, eight zero words. Required: sig walks 02, 04, … 80, then ends at 8'h1D.
- Gapped valid plus ignored inputs. Run the first scenario with in_valid gaps of 3 cycles. Also drive in_valid in IDLE, DONE, and a third word after the count completes. Required: result is still 8'hB3 and busy is low in DONE.
- Start handling. Pulse start mid-RUN: ignored, result unchanged. Pulse start in DONE: sig_valid drops the next cycle and sig=SEED. Assert start and in_valid together: that word is excluded.
- Asynchronous reset. Assert resetn=0 mid-RUN, between clock edges. Required: sig=SEED, busy=0, sig_valid=0 immediately. A following full run matches the reference model.
- Default configuration. 1024 random 500-bit words (pad top slice 20 bits). Required: sig matches the package xor_fold plus software MISR model bit-exactly.
